// File: rtl/bus_read_ctrl_pkg.sv
// Shared bus definitions: FSM state encodings, bus width and the RAM slot code
// that every bus decoder must agree on.
package bus_read_ctrl_pkg;

    localparam int BUS_DW      = 8;
    localparam int BUS_MEM_SEL = 7;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_WAIT = 2'd1,
        DRIVE    = 2'd2
    } rd_state_t;

endpackage

// File: rtl/bus_read_ctrl.sv
// Read-side bus source controller: registers one register slot or the data RAM
// onto BusOut with a one-cycle bus_valid strobe, hiding RAM read latency.
module bus_read_ctrl
    import bus_read_ctrl_pkg::*;
#(
    parameter int DW      = BUS_DW,
    parameter int NSRC    = 8,
    parameter int SELW    = 3,
    parameter int MEM_SEL = BUS_MEM_SEL,
    parameter int MEM_LAT = 2
) (
    input  logic                Clk,
    input  logic                RST,
    input  logic                rd_req,
    input  logic [SELW-1:0]     rd_sel,
    input  logic [NSRC*DW-1:0]  src_data,
    input  logic [DW-1:0]       mem_rdata,
    output logic                mem_ren,
    output logic [DW-1:0]       BusOut,
    output logic                bus_valid,
    output logic                busy,
    output logic                sel_err
);

    localparam logic [SELW-1:0] MEM_SEL_W = SELW'(MEM_SEL);
    localparam logic [SELW:0]   NSRC_W    = (SELW+1)'(NSRC);
    localparam logic [2:0]      LAT_INIT  = 3'(MEM_LAT - 1);

    // The latency counter is 3 bits wide, so only 1..7 cycles can be timed.
    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_bad_lat
        $error("bus_read_ctrl: MEM_LAT=%0d outside 1..7", MEM_LAT);
    end
    if ((1 << SELW) < NSRC) begin : g_bad_selw
        $error("bus_read_ctrl: SELW=%0d too narrow for NSRC=%0d", SELW, NSRC);
    end

    rd_state_t       state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [DW-1:0]   bus_d;
    logic            valid_d, busy_d, ren_d, err_d;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = BusOut;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        ren_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    if (rd_sel == MEM_SEL_W) begin
                        ren_d   = 1'b1;
                        busy_d  = 1'b1;
                        cnt_d   = LAT_INIT;
                        state_d = MEM_WAIT;
                    end else if ({1'b0, rd_sel} >= NSRC_W) begin
                        bus_d   = '0;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        bus_d   = src_data[rd_sel*DW +: DW];
                        valid_d = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (cnt_q == 3'd0) begin
                    bus_d   = mem_rdata;
                    valid_d = 1'b1;
                    state_d = DRIVE;
                end else begin
                    cnt_d  = cnt_q - 3'd1;
                    busy_d = 1'b1;
                end
            end
            // One dead cycle after each RAM read; requests here are dropped.
            DRIVE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from values sampled before the edge.
    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            BusOut    <= '0;
            bus_valid <= 1'b0;
            busy      <= 1'b0;
            mem_ren   <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            BusOut    <= bus_d;
            bus_valid <= valid_d;
            busy      <= busy_d;
            mem_ren   <= ren_d;
            sel_err   <= err_d;
        end
    end

endmodule
